// File: rtl/ysyx_25060166_lsu_if.sv
// Bundle of EXU request/response handshake and data-memory access signals for the LSU.
// Memory side: one access strobe per request; read data is sampled by the LSU on that edge.
interface ysyx_25060166_lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_valid;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [2:0]    mem_len;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_we, mem_addr, mem_len, mem_wdata
  );

  modport mem (
    input  mem_valid, mem_we, mem_addr, mem_len, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ysyx_25060166_lsu.sv
// Load/store unit: one outstanding request, memory access exactly LATENCY cycles after accept.
// Optional YSYX_25060166_LSU_ERR_EN: misaligned/size-3 requests fault instead of being force-aligned.
module ysyx_25060166_lsu #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input logic                clk,
  input logic                rst,
  ysyx_25060166_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, uns_q, fault_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          accept_s, access_s, in_fault_s;
  logic [1:0]    in_size_s;
  logic [AW-1:0] in_addr_s;

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    r = {{24{b[7] & ~uns}}, b};
      2'd1:    r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept_s = (state_q == IDLE) && bus.req_valid;
  assign access_s = (state_q == WAIT) && (cnt_q == 4'd0);

  // Request legality check (fault build) or force-alignment (default build)
  always_comb begin
    in_size_s  = bus.req_size;
    in_addr_s  = bus.req_addr;
    in_fault_s = 1'b0;
`ifdef YSYX_25060166_LSU_ERR_EN
    case (bus.req_size)
      2'd0:    in_fault_s = 1'b0;
      2'd1:    in_fault_s = bus.req_addr[0];
      2'd2:    in_fault_s = (bus.req_addr[1:0] != 2'b00);
      default: in_fault_s = 1'b1;
    endcase
`else
    case (bus.req_size)
      2'd0:    in_addr_s = bus.req_addr;
      2'd1:    in_addr_s = {bus.req_addr[AW-1:1], 1'b0};
      default: begin
        in_size_s = 2'd2;
        in_addr_s = {bus.req_addr[AW-1:2], 2'b00};
      end
    endcase
`endif
  end

  // Next-state, countdown and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (access_s) begin
          state_d = RESP;
          err_d   = fault_q;
          rdata_d = (fault_q || we_q) ? {DW{1'b0}} : load_ext(bus.mem_rdata, size_q, uns_q, addr_q[1:0]);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= {DW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture; fields stay frozen until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DW{1'b0}};
    end else if (accept_s) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      fault_q <= in_fault_s;
      size_q  <= in_size_s;
      addr_q  <= in_addr_s;
      wdata_q <= bus.req_wdata;
    end else begin
      we_q    <= we_q;
      uns_q   <= uns_q;
      fault_q <= fault_q;
      size_q  <= size_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
    end
  end

  // Store length and right-aligned, zero-padded store data
  always_comb begin
    bus.mem_len   = 3'd4;
    bus.mem_wdata = wdata_q[31:0];
    case (size_q)
      2'd0: begin
        bus.mem_len   = 3'd1;
        bus.mem_wdata = {24'h000000, wdata_q[7:0]};
      end
      2'd1: begin
        bus.mem_len   = 3'd2;
        bus.mem_wdata = {16'h0000, wdata_q[15:0]};
      end
      default: begin
        bus.mem_len   = 3'd4;
        bus.mem_wdata = wdata_q[31:0];
      end
    endcase
  end

  assign bus.mem_valid  = access_s && !fault_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = we_q ? 32'(addr_q) : 32'({addr_q[AW-1:2], 2'b00});
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_ysyx_25060166_lsu.sv
// Randomized bench for ysyx_25060166_lsu with a byte-level reference memory and timing model.
module tb_ysyx_25060166_lsu;
  localparam int LAT = 4;

  logic clk;
  logic rst;
  ysyx_25060166_lsu_if #(.AW(32), .DW(32)) ifc ();

  ysyx_25060166_lsu #(.AW(32), .DW(32), .LATENCY(LAT)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  // Simulated data memory: 64 bytes at 0x80000000
  logic [7:0] dev_mem [0:63];
  int rd_calls = 0;
  int wr_calls = 0;

  // Timing model: pending flag and edges elapsed since accept
  bit m_pend = 1'b0;
  int m_age  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_age  <= 0;
    end else if (!m_pend) begin
      if (ifc.req_valid) begin
        m_pend <= 1'b1;
        m_age  <= 0;
      end
    end else if (m_age < LAT) begin
      m_age <= m_age + 1;
    end else if (ifc.resp_ready) begin
      m_pend <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= 8'h00;
    end else if (ifc.mem_valid) begin
      chk("access_edge", 32'(m_pend && (m_age == LAT - 1)), 32'd1);
      chk("mem_addr_hi", ifc.mem_addr & 32'hFFFFFFC0, 32'h80000000);
      if (ifc.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (i < int'(ifc.mem_len)) dev_mem[6'(ifc.mem_addr[5:0] + 6'(i))] <= ifc.mem_wdata[8*i +: 8];
        wr_calls <= wr_calls + 1;
      end else begin
        rd_calls <= rd_calls + 1;
      end
    end
  end

  always @(negedge clk) begin
    ifc.mem_rdata <= {dev_mem[{ifc.mem_addr[5:2], 2'd3}], dev_mem[{ifc.mem_addr[5:2], 2'd2}],
                      dev_mem[{ifc.mem_addr[5:2], 2'd1}], dev_mem[{ifc.mem_addr[5:2], 2'd0}]};
  end

  // Reference model of the memory contents and the expected response
  bit [7:0]  ref_mem [0:63];
  bit [31:0] exp_rdata = 32'd0;
  bit        exp_err   = 1'b0;
  int        exp_rd    = 0;
  int        exp_wr    = 0;

  task automatic model_access(input bit we, input bit [1:0] sz, input bit uns,
                              input bit [31:0] a, input bit [31:0] wd);
    bit fault;
    bit [1:0] s;
    bit [31:0] ea, v;
    int len;
    s = sz;
    ea = a;
    fault = 1'b0;
`ifdef YSYX_25060166_LSU_ERR_EN
    fault = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
    if (sz == 2'd3) s = 2'd2;
    if (s == 2'd1) ea = a & ~32'd1;
    if (s == 2'd2) ea = a & ~32'd3;
`endif
    len = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    if (fault) begin
      exp_rdata = 32'd0;
      exp_err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < len; i++) ref_mem[6'(ea + 32'(i))] = 8'(wd >> (8 * i));
      exp_wr++;
      exp_rdata = 32'd0;
      exp_err = 1'b0;
    end else begin
      v = 32'd0;
      for (int i = 0; i < len; i++) v = v | (32'(ref_mem[6'(ea + 32'(i))]) << (8 * i));
      if (!uns && len == 1 && v[7]) v = v | 32'hFFFFFF00;
      if (!uns && len == 2 && v[15]) v = v | 32'hFFFF0000;
      exp_rd++;
      exp_rdata = v;
      exp_err = 1'b0;
    end
  endtask

  // Cycle-by-cycle compare of handshake and response against the model
  always @(negedge clk) begin
    if (!rst && checking) begin
      chk("req_ready", 32'(ifc.req_ready), 32'(!m_pend));
      chk("resp_valid", 32'(ifc.resp_valid), 32'(m_pend && m_age == LAT));
      if (m_pend && m_age == LAT) begin
        chk("resp_rdata", ifc.resp_rdata, exp_rdata);
        chk("resp_err", 32'(ifc.resp_err), 32'(exp_err));
      end
    end
  end

  task automatic do_req(input bit we, input bit [1:0] sz, input bit uns, input bit [31:0] a,
                        input bit [31:0] wd, input int stall,
                        output bit [31:0] rd, output bit er, output int lat);
    int n;
    model_access(we, sz, uns, a, wd);
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_we = we;
    ifc.req_size = sz;
    ifc.req_unsigned = uns;
    ifc.req_addr = a;
    ifc.req_wdata = wd;
    n = 0;
    while (!ifc.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    lat = 0;
    while (!ifc.resp_valid && lat < 100) begin
      ifc.req_valid = 1'($urandom);
      ifc.req_we = 1'($urandom);
      ifc.req_size = 2'($urandom);
      ifc.req_addr = $urandom;
      ifc.req_wdata = $urandom;
      @(negedge clk);
      lat++;
    end
    ifc.req_valid = 1'b0;
    if (lat >= 100) chk("resp_timeout", 32'(lat), 32'(LAT));
    rd = ifc.resp_rdata;
    er = ifc.resp_err;
    repeat (stall) @(negedge clk);
    ifc.resp_ready = 1'b1;
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    chk("rd_calls", 32'(rd_calls), 32'(exp_rd));
    chk("wr_calls", 32'(wr_calls), 32'(exp_wr));
  endtask

  initial begin
    bit [31:0] rd;
    bit er;
    int lat, rd0, wr0;
    rst = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_we = 1'b0;
    ifc.req_size = 2'd0;
    ifc.req_unsigned = 1'b0;
    ifc.req_addr = 32'd0;
    ifc.req_wdata = 32'd0;
    ifc.resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    chk("rst_resp_rdata", ifc.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(ifc.resp_err), 32'd0);
    checking = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 32'h80000000, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_latency", 32'(lat), 32'd4);
    do_req(1'b0, 2'd0, 1'b0, 32'h80000003, 32'd0, 0, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFFDE);
    chk("lb_err", 32'(er), 32'd0);
    do_req(1'b1, 2'd1, 1'b0, 32'h80000002, 32'h00008001, 1, rd, er, lat);
    do_req(1'b0, 2'd1, 1'b1, 32'h80000002, 32'd0, 0, rd, er, lat);
    chk("lhu", rd, 32'h00008001);
    do_req(1'b0, 2'd1, 1'b0, 32'h80000002, 32'd0, 2, rd, er, lat);
    chk("lh_signed", rd, 32'hFFFF8001);
    chk("load_latency", 32'(lat), 32'd4);

    rd0 = rd_calls;
    do_req(1'b0, 2'd2, 1'b0, 32'h80000000, 32'd0, 10, rd, er, lat);
    chk("stall_lw", rd, 32'h8001BEEF);
    chk("stall_rd_delta", 32'(rd_calls - rd0), 32'd1);

    wr0 = wr_calls;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_we = 1'b1;
    ifc.req_size = 2'd2;
    ifc.req_addr = 32'h80000000;
    ifc.req_wdata = 32'h12345678;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    repeat (LAT) @(negedge clk);
    chk("midrst_wr_delta", 32'(wr_calls - wr0), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h80000000, 32'd0, 0, rd, er, lat);
    chk("midrst_mem_kept", rd, 32'h8001BEEF);

    rd0 = rd_calls;
    do_req(1'b0, 2'd2, 1'b0, 32'h80000001, 32'd0, 0, rd, er, lat);
`ifdef YSYX_25060166_LSU_ERR_EN
    chk("mis_lw_rdata", rd, 32'd0);
    chk("mis_lw_err", 32'(er), 32'd1);
    chk("mis_lw_rd_delta", 32'(rd_calls - rd0), 32'd0);
`else
    chk("mis_lw_rdata", rd, 32'h8001BEEF);
    chk("mis_lw_err", 32'(er), 32'd0);
    chk("mis_lw_rd_delta", 32'(rd_calls - rd0), 32'd1);
`endif

    for (int k = 0; k < 250; k++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'h80000000 + $urandom_range(0, 63),
             $urandom, $urandom_range(0, 3), rd, er, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
